// File: rtl/npc_pipe_unit_if.sv
// Handshake bundle between the controller/IM side and the next-PC unit.
// The slave modport is the PC unit itself; the master modport is whatever drives the selectors.
interface npc_pipe_unit_if #(
   parameter int AW = 32
);
   logic          stall;
   logic [2:0]    npc_sel;
   logic          link;
   logic          ra_src;
   logic          zero;
   logic          bgez_flag;
   logic [31:0]   instr;
   logic [AW-1:0] reg_addr;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_plus4;
   logic          taken;
   logic          ras_mispred;
   logic [4:0]    ras_count;

   modport master (
      output stall, npc_sel, link, ra_src, zero, bgez_flag, instr, reg_addr,
      input  pc, pc_plus4, taken, ras_mispred, ras_count
   );

   modport slave (
      input  stall, npc_sel, link, ra_src, zero, bgez_flag, instr, reg_addr,
      output pc, pc_plus4, taken, ras_mispred, ras_count
   );
endinterface

// File: rtl/npc_pipe_unit.sv
// Registered PC and next-PC selection (+4, BEQ/BNE/BGEZ, J/JAL, JR) for the MIPS core.
// Optional return-address stack that checks JR $ra targets, enabled by defining NPC_RAS_EN.
module npc_pipe_unit #(
   parameter int            AW        = 32,
   parameter logic [AW-1:0] RESET_PC  = AW'(32'h0000_3000),
   parameter int            RAS_DEPTH = 4
) (
   input logic             clk,
   input logic             reset,
   npc_pipe_unit_if.slave  io_npc
);

   localparam logic [2:0] SEL_SEQ  = 3'b000;
   localparam logic [2:0] SEL_BEQ  = 3'b001;
   localparam logic [2:0] SEL_BNE  = 3'b010;
   localparam logic [2:0] SEL_BGEZ = 3'b011;
   localparam logic [2:0] SEL_J    = 3'b100;
   localparam logic [2:0] SEL_JR   = 3'b101;

   logic [AW-1:0]    r_pc;
   logic [AW-1:0]    w_seq;
   logic [AW+17:0]   w_off_wide;
   logic [AW-1:0]    w_br;
   logic [AW-1:0]    w_jmp;
   logic [AW-1:0]    w_jr;
   logic [AW-1:0]    w_target;
   logic [AW-1:0]    w_next;
   logic             w_taken;

   assign w_seq      = r_pc + AW'(4);
   assign w_off_wide = {{AW{io_npc.instr[15]}}, io_npc.instr[15:0], 2'b00};
   assign w_br       = w_seq + w_off_wide[AW-1:0];
   assign w_jr       = {io_npc.reg_addr[AW-1:2], 2'b00};

   // Region-relative jump: upper bits come from the delay-slot PC, not the current PC.
   generate
      if (AW > 28) begin : g_jmp_wide
         assign w_jmp = {w_seq[AW-1:28], io_npc.instr[25:0], 2'b00};
      end else begin : g_jmp_narrow
         logic [27:0] w_jidx;
         assign w_jidx = {io_npc.instr[25:0], 2'b00};
         assign w_jmp  = w_jidx[AW-1:0];
      end
   endgenerate

   // Redirect decision and target choice for the current selector.
   always_comb begin
      w_taken  = 1'b0;
      w_target = w_seq;
      case (io_npc.npc_sel)
         SEL_SEQ: begin
            w_taken  = 1'b0;
            w_target = w_seq;
         end
         SEL_BEQ: begin
            w_taken  = io_npc.zero;
            w_target = w_br;
         end
         SEL_BNE: begin
            w_taken  = ~io_npc.zero;
            w_target = w_br;
         end
         SEL_BGEZ: begin
            w_taken  = io_npc.bgez_flag;
            w_target = w_br;
         end
         SEL_J: begin
            w_taken  = 1'b1;
            w_target = w_jmp;
         end
         SEL_JR: begin
            w_taken  = 1'b1;
            w_target = w_jr;
         end
         default: begin
            w_taken  = 1'b0;
            w_target = w_seq;
         end
      endcase
   end

   assign w_next = w_taken ? w_target : w_seq;

   // PC register; stall freezes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else if (!io_npc.stall) begin
         r_pc <= w_next;
      end
   end

   assign io_npc.pc       = r_pc;
   assign io_npc.pc_plus4 = w_seq;
   assign io_npc.taken    = w_taken;

`ifdef NPC_RAS_EN
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [AW-1:0] r_ras [RAS_DEPTH];
   logic [PW-1:0] r_sp;
   logic [4:0]    r_count;
   logic          r_mispred;
   logic          w_push;
   logic          w_pop;
   logic [AW-1:0] w_top;
   logic          w_unused_ok;

   // BGEZAL pushes even when not taken, since $ra is written either way.
   assign w_push = ~io_npc.stall & io_npc.link &
                   ((io_npc.npc_sel == SEL_BGEZ) | (io_npc.npc_sel == SEL_J));
   assign w_pop  = ~io_npc.stall & io_npc.ra_src & (io_npc.npc_sel == SEL_JR);
   assign w_top  = r_ras[r_sp - PW'(1)];

   // Circular stack: a push onto a full stack overwrites the oldest slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            r_ras[i] <= '0;
         end
         r_sp      <= '0;
         r_count   <= 5'd0;
         r_mispred <= 1'b0;
      end else if (w_push) begin
         r_ras[r_sp] <= w_seq;
         r_sp        <= r_sp + PW'(1);
         if (r_count != 5'(RAS_DEPTH)) begin
            r_count <= r_count + 5'd1;
         end
      end else if (w_pop) begin
         if (r_count == 5'd0) begin
            r_mispred <= 1'b1;
         end else begin
            r_mispred <= (w_top != w_jr);
            r_sp      <= r_sp - PW'(1);
            r_count   <= r_count - 5'd1;
         end
      end
   end

   assign io_npc.ras_count   = r_count;
   assign io_npc.ras_mispred = r_mispred;
   assign w_unused_ok        = &{1'b0, io_npc.instr[31:26], io_npc.reg_addr[1:0]};
`else
   logic w_unused_ok;

   assign io_npc.ras_count   = 5'd0;
   assign io_npc.ras_mispred = 1'b0;
   assign w_unused_ok        = &{1'b0, io_npc.instr[31:26], io_npc.reg_addr[1:0],
                                 io_npc.link, io_npc.ra_src};
`endif

endmodule

// File: tb/tb_npc_pipe_unit.sv
// Directed bench for npc_pipe_unit; RAS expectations follow whether NPC_RAS_EN is defined.
module tb_npc_pipe_unit;

`ifdef NPC_RAS_EN
   localparam bit RAS = 1'b1;
`else
   localparam bit RAS = 1'b0;
`endif

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;
   logic [31:0] lnk [5];

   npc_pipe_unit_if #(.AW(32)) io ();

   npc_pipe_unit #(.AW(32), .RESET_PC(32'h0000_3000), .RAS_DEPTH(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_npc (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] sel, input logic lk, input logic rs, input logic z,
                        input logic bg, input logic [31:0] ins, input logic [31:0] ra);
      io.npc_sel   = sel;
      io.link      = lk;
      io.ra_src    = rs;
      io.zero      = z;
      io.bgez_flag = bg;
      io.instr     = ins;
      io.reg_addr  = ra;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic jr(input logic [31:0] ra);
      drive(3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, ra);
      step();
   endtask

   task automatic jmp(input logic [31:0] tgt);
      drive(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, {6'b000010, tgt[27:2]}, 32'd0);
      step();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      io.stall = 1'b0;
      drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      #2;
      chk("reset_pc", io.pc, 32'h0000_3000);
      chk("reset_cnt", 32'(io.ras_count), 32'd0);
      chk("reset_mis", 32'(io.ras_mispred), 32'd0);
      step();
      chk("reset_hold", io.pc, 32'h0000_3000);
      reset = 1'b0;
      step(); chk("seq1", io.pc, 32'h0000_3004);
      step(); chk("seq2", io.pc, 32'h0000_3008);
      step(); chk("seq3", io.pc, 32'h0000_300C);

      // asynchronous reset mid-run
      step();
      reset = 1'b1;
      #1;
      chk("async_rst", io.pc, 32'h0000_3000);
      #1;
      reset = 1'b0;
      step(); chk("post_rst1", io.pc, 32'h0000_3004);
      step(); chk("post_rst2", io.pc, 32'h0000_3008);
      step(); chk("post_rst3", io.pc, 32'h0000_300C);
      step(); chk("to_3010", io.pc, 32'h0000_3010);

      // conditional branches from 0x3010 with imm16 = -4
      drive(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_FFFC, 32'd0);
      #1;
      chk("beq_taken", 32'(io.taken), 32'd1);
      chk("pc_plus4", io.pc_plus4, 32'h0000_3014);
      step(); chk("beq_z1", io.pc, 32'h0000_3004);
      jmp(32'h0000_3010); chk("j_3010a", io.pc, 32'h0000_3010);
      drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_FFFC, 32'd0);
      #1;
      chk("beq_ntaken", 32'(io.taken), 32'd0);
      step(); chk("beq_z0", io.pc, 32'h0000_3014);
      jmp(32'h0000_3010);
      drive(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_FFFC, 32'd0);
      step(); chk("bne_z0", io.pc, 32'h0000_3004);
      jmp(32'h0000_3010);
      drive(3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_FFFC, 32'd0);
      step(); chk("bne_z1", io.pc, 32'h0000_3014);
      drive(3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'd0);
      step(); chk("bgez_t", io.pc, 32'h0000_3058);
      drive(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'd0);
      step(); chk("bgez_nt", io.pc, 32'h0000_305C);
      drive(3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_FFFF, 32'd0);
      step(); chk("bgez_neg", io.pc, 32'h0000_305C);

      // J and JR
      jmp(32'h0000_3000); chk("j_3000", io.pc, 32'h0000_3000);
      drive(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, {6'b000010, 26'h0000C10}, 32'd0);
      step(); chk("j_c10", io.pc, 32'h0000_3040);
      jr(32'h0000_3047); chk("jr_align", io.pc, 32'h0000_3044);

      // stall holds PC and RAS while a JAL waits
      io.stall = 1'b1;
      drive(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, {6'b000011, 26'h0000100}, 32'd0);
      step(); chk("stall1", io.pc, 32'h0000_3044);
      step(); chk("stall2", io.pc, 32'h0000_3044);
      step(); chk("stall3", io.pc, 32'h0000_3044);
      chk("stall_cnt", 32'(io.ras_count), 32'd0);
      io.stall = 1'b0;
      step(); chk("unstall", io.pc, 32'h0000_0400);
      chk("unstall_cnt", 32'(io.ras_count), RAS ? 32'd1 : 32'd0);
      drive(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_3048);
      step(); chk("ret_pc", io.pc, 32'h0000_3048);
      chk("ret_cnt", 32'(io.ras_count), 32'd0);
      chk("ret_mis", 32'(io.ras_mispred), 32'd0);

      // reserved selectors act as +4 and do not touch the stack
      drive(3'b110, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_FFFF, 32'd0);
      #1;
      chk("rsv_taken", 32'(io.taken), 32'd0);
      step(); chk("rsv110", io.pc, 32'h0000_304C);
      drive(3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_FFFF, 32'd0);
      step(); chk("rsv111", io.pc, 32'h0000_3050);
      chk("rsv_cnt", 32'(io.ras_count), 32'd0);
      chk("rsv_mis", 32'(io.ras_mispred), 32'd0);

      // wrap-around cases
      jr(32'hFFFF_FFFF); chk("jr_top", io.pc, 32'hFFFF_FFFC);
      drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      chk("p4_wrap", io.pc_plus4, 32'h0000_0000);
      step(); chk("seq_wrap", io.pc, 32'h0000_0000);
      jr(32'hFFFF_FFFC);
      drive(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'd0);
      step(); chk("br_wrap", io.pc, 32'h0000_0004);
      drive(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_8000, 32'd0);
      step(); chk("br_minneg", io.pc, 32'hFFFE_0008);
      jr(32'h2FFF_FFFC);
      drive(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, {6'b000010, 26'h0000001}, 32'd0);
      step(); chk("j_region", io.pc, 32'h3000_0004);

      // five nested calls, then five returns
      jr(32'h0000_1000);
      for (int i = 0; i < 5; i++) begin
         logic [31:0] p;
         logic [31:0] t;
         p = 32'h0000_1000 + 32'(i) * 32'h100;
         t = p + 32'h100;
         lnk[i] = p + 32'd4;
         drive(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, {6'b000011, t[27:2]}, 32'd0);
         step();
         chk("jal_pc", io.pc, t);
         chk("jal_cnt", 32'(io.ras_count), RAS ? ((i < 4) ? 32'(i + 1) : 32'd4) : 32'd0);
      end
      for (int j = 0; j < 5; j++) begin
         drive(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, lnk[4 - j]);
         step();
         chk("ret_pc", io.pc, lnk[4 - j]);
         chk("ret_mis", 32'(io.ras_mispred), (RAS && j == 4) ? 32'd1 : 32'd0);
         chk("ret_cnt", 32'(io.ras_count), (RAS && j < 4) ? 32'(3 - j) : 32'd0);
      end

      // BGEZAL not taken still pushes; mispred holds until the next pop
      drive(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'd0);
      step(); chk("bgezal_pc", io.pc, 32'h0000_1008);
      chk("bgezal_cnt", 32'(io.ras_count), RAS ? 32'd1 : 32'd0);
      chk("mis_hold", 32'(io.ras_mispred), RAS ? 32'd1 : 32'd0);
      drive(3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_1008);
      step(); chk("jr_nora_cnt", 32'(io.ras_count), RAS ? 32'd1 : 32'd0);
      drive(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_1008);
      step(); chk("ok_ret_mis", 32'(io.ras_mispred), 32'd0);
      chk("ok_ret_cnt", 32'(io.ras_count), 32'd0);
      drive(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, {6'b000011, 26'h0000800}, 32'd0);
      step(); chk("jal2_pc", io.pc, 32'h0000_2000);
      drive(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_2222);
      step(); chk("bad_ret_pc", io.pc, 32'h0000_2220);
      chk("bad_ret_mis", 32'(io.ras_mispred), RAS ? 32'd1 : 32'd0);
      chk("bad_ret_cnt", 32'(io.ras_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
